counter_sequencer: RTL

Command sequencer and arbiter for the 12-bit up/down counter with parallel load (COUNTER_12bit). It accepts LOAD, UP, DOWN and CLEAR commands from NREQ requesters over valid/ready handshakes and grants the counter to one requester at a time. It then drives the counter's enable, load, up_down, data and reset_n pins for the exact number of cycles each command needs. Each completed command returns one response carrying the requester id and the resulting count.

---
 rtl/counter_seq_pkg.sv | 7 +
 rtl/counter_seq_arbiter.sv | 41 ++++
 rtl/counter_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: command/state types and default sizes shared by counter_sequencer and its arbiter.
package counter_seq_pkg;
   localparam int WIDTH_DEF = 12;
   localparam int NREQ_DEF  = 2;
   typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_CLEAR = 2'b11} op_e;
   typedef enum logic [2:0] {S_IDLE = 3'd0, S_LOAD = 3'd1, S_CLEAR = 3'd2, S_RUN = 3'd3, S_RESP = 3'd4} state_e;
endpackage

// File: rtl/counter_seq_arbiter.sv
// counter_seq_arbiter: one-hot grant among valid requesters.
// COUNTER_SEQ_RR_EN defined: round-robin from a pointer; otherwise the lowest id wins.
module counter_seq_arbiter import counter_seq_pkg::*; #(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = 1
) (
`ifdef COUNTER_SEQ_RR_EN
   input  logic            clk,
   input  logic            reset,
`endif
   input  logic [NREQ-1:0] i_valid,
   input  logic            i_en,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_id
);
   logic [IDW-1:0] w_ptr;
   logic [IDW:0]   w_idx;
`ifdef COUNTER_SEQ_RR_EN
   logic [IDW-1:0] r_ptr;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_ptr <= '0;
      else if (|o_grant) r_ptr <= (o_id == IDW'(NREQ - 1)) ? '0 : o_id + 1'b1;
   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif
   // Scan NREQ slots starting at the pointer, wrapping at NREQ; first valid one wins.
   always_comb begin
      o_grant = '0;
      o_id    = '0;
      w_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = {1'b0, w_ptr} + (IDW+1)'(k);
         if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
         if (i_en && o_grant == '0 && i_valid[w_idx[IDW-1:0]]) begin
            o_grant[w_idx[IDW-1:0]] = 1'b1;
            o_id = w_idx[IDW-1:0];
         end
      end
   end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: arbitrates LOAD/UP/DOWN/CLEAR commands and drives a WIDTH-bit up/down counter.
// Arbitration is round-robin when COUNTER_SEQ_RR_EN is defined, fixed priority otherwise.
module counter_sequencer import counter_seq_pkg::*; #(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int NREQ  = NREQ_DEF,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0][1:0]       req_op,
   input  logic [NREQ-1:0][WIDTH-1:0] req_arg,
   output logic                       rsp_valid,
   output logic [IDW-1:0]             rsp_id,
   output logic [WIDTH-1:0]           rsp_count,
   output logic                       cnt_enable,
   output logic                       cnt_load,
   output logic                       cnt_up_down,
   output logic                       cnt_reset_n,
   output logic [WIDTH-1:0]           cnt_data,
   input  logic [WIDTH-1:0]           cnt_count
);
   state_e           r_state;
   op_e              r_op;
   logic [IDW-1:0]   r_id, r_rsp_id;
   logic [WIDTH-1:0] r_steps, r_data;
   logic             r_enable, r_load, r_up_down, r_reset_n, r_rsp_valid;
   logic [NREQ-1:0]  w_grant;
   logic [IDW-1:0]   w_id;
   op_e              w_op;
   logic [WIDTH-1:0] w_arg;
   logic             w_en;
   assign w_en  = (r_state == S_IDLE) && !reset;
   assign w_op  = op_e'(req_op[w_id]);
   assign w_arg = req_arg[w_id];
   counter_seq_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
`ifdef COUNTER_SEQ_RR_EN
      .clk     (clk),
      .reset   (reset),
`endif
      .i_valid (req_valid),
      .i_en    (w_en),
      .o_grant (w_grant),
      .o_id    (w_id)
   );
   assign req_ready   = w_grant;
   assign cnt_enable  = r_enable;
   assign cnt_load    = r_load;
   assign cnt_up_down = r_up_down;
   assign cnt_data    = r_data;
   assign cnt_reset_n = r_reset_n & ~reset;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_rsp_id;
   // The counter has settled by the RESP cycle, so its value is passed straight through.
   assign rsp_count   = r_rsp_valid ? cnt_count : '0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op        <= OP_LOAD;
         r_id        <= '0;
         r_steps     <= '0;
         r_enable    <= 1'b0;
         r_load      <= 1'b0;
         r_up_down   <= 1'b0;
         r_data      <= '0;
         r_reset_n   <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
      end else begin
         r_enable    <= 1'b0;
         r_load      <= 1'b0;
         r_up_down   <= 1'b0;
         r_data      <= '0;
         r_reset_n   <= 1'b1;
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: if (|w_grant) begin
               r_id    <= w_id;
               r_op    <= w_op;
               r_steps <= w_arg;
               if (w_op == OP_LOAD) begin
                  r_state  <= S_LOAD;
                  r_load   <= 1'b1;
                  r_enable <= 1'b1;
                  r_data   <= w_arg;
               end else if (w_op == OP_CLEAR) begin
                  r_state   <= S_CLEAR;
                  r_reset_n <= 1'b0;
               end else if (w_arg == '0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_id    <= w_id;
               end else begin
                  r_state   <= S_RUN;
                  r_enable  <= 1'b1;
                  r_up_down <= (w_op == OP_UP);
               end
            end
            S_LOAD, S_CLEAR: begin
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_id    <= r_id;
            end
            S_RUN: if (r_steps == WIDTH'(1)) begin
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_id    <= r_id;
            end else begin
               r_steps   <= r_steps - 1'b1;
               r_enable  <= 1'b1;
               r_up_down <= (r_op == OP_UP);
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
